// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BIT_IDX_W  = 3;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIVISOR-1 while a frame is running and flags the last clock.
module uart_baud_gen #(
    parameter int unsigned DIVISOR = 434
) (
    input  logic clk,
    input  logic rst_,
    input  logic run,
    output logic baud_tick_c
);

    localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CNT_W-1:0] baud_cnt_q;
    logic [CNT_W-1:0] baud_cnt_d;

    // Counter rests at zero while idle so every frame starts on a full bit period.
    always_comb begin
        baud_cnt_d  = '0;
        baud_tick_c = run && (baud_cnt_q == CNT_W'(DIVISOR - 1));
        if (run && !baud_tick_c) begin
            baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART serializer: start bit, 8 data bits LSB first, stop bit; one bit per DIVISOR clocks.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_serial,
    output logic       tx_busy
);

    localparam int unsigned DIVISOR = CLK_FREQ / BAUD_RATE;

    uart_state_e              state_q,     state_d;
    logic [DATA_BITS-1:0]     data_q,      data_d;
    logic [BIT_IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic                     tx_serial_q, tx_serial_d;
    logic                     tx_busy_q,   tx_busy_d;
    logic                     baud_tick;

    uart_baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud_gen (
        .clk         (clk),
        .rst_        (rst_),
        .run         (state_q != IDLE),
        .baud_tick_c (baud_tick)
    );

    // Next-state and line-level logic; the line only moves on a bit boundary.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        bit_idx_d   = bit_idx_q;
        tx_serial_d = tx_serial_q;
        tx_busy_d   = tx_busy_q;

        unique case (state_q)
            IDLE: begin
                tx_serial_d = 1'b1;
                tx_busy_d   = 1'b0;
                if (tx_start) begin
                    data_d      = tx_data;
                    state_d     = START;
                    tx_serial_d = 1'b0;
                    tx_busy_d   = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_serial_d = data_q[0];
                    bit_idx_d   = '0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q != BIT_IDX_W'(DATA_BITS - 1)) begin
                        tx_serial_d = data_q[bit_idx_q + BIT_IDX_W'(1)];
                        bit_idx_d   = bit_idx_q + BIT_IDX_W'(1);
                    end else begin
                        tx_serial_d = 1'b1;
                        state_d     = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d     = IDLE;
                    tx_busy_d   = 1'b0;
                    tx_serial_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                tx_serial_d = 1'b1;
                tx_busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= IDLE;
            data_q      <= '0;
            bit_idx_q   <= '0;
            tx_serial_q <= 1'b1;
            tx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            bit_idx_q   <= bit_idx_d;
            tx_serial_q <= tx_serial_d;
            tx_busy_q   <= tx_busy_d;
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized self-checking bench for uart_transmitter against a frame-level line model.
module tb_uart_transmitter;

    localparam int unsigned CLK_FREQ  = 50_000_000;
    localparam int unsigned BAUD_RATE = 115200;
    localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_serial;
    logic       tx_busy;

    int     vectors = 0;
    int     errors  = 0;
    longint cyc       = 0;
    longint last_tick = 0;

    uart_transmitter #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Line level seen during bit k of the frame carrying b: start 0, data LSB first, stop 1.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Bounded wait for the next baud_tick; gap is clocks since the previous one.
    task automatic wait_tick(output bit ok, output longint gap);
        ok  = 1'b0;
        gap = 0;
        for (int i = 0; i < int'(2 * DIV) + 10; i++) begin
            @(negedge clk);
            if (dut.baud_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            gap       = cyc - last_tick;
            last_tick = cyc;
        end
    endtask

    task automatic test_reset;
        rst_     = 1'b0;
        tx_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_during: serial=%b busy=%b expected serial=1 busy=0", tx_serial, tx_busy);
        end
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: serial=%b busy=%b expected serial=1 busy=0", tx_serial, tx_busy);
        end
    endtask

    task automatic test_all_ones;
        bit ok; longint gap; logic [9:0] exp;
        exp = frame_of(8'hFF);
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx_busy !== 1'b1 || tx_serial !== 1'b0) begin
            errors++;
            $display("FAIL ff_accept: serial=%b busy=%b expected serial=0 busy=1", tx_serial, tx_busy);
        end
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_tick(ok, gap);
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL ff_tick%0d: no baud_tick within bound, expected one", k);
            end else if (tx_serial !== exp[k]) begin
                errors++;
                $display("FAIL ff_bit%0d: serial=%b expected %b", k, tx_serial, exp[k]);
            end
        end
        @(negedge clk);
        vectors++;
        if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL ff_end: serial=%b busy=%b expected serial=1 busy=0", tx_serial, tx_busy);
        end
    endtask

    task automatic test_all_zeros;
        bit ok; longint gap; logic [9:0] exp;
        exp = frame_of(8'h00);
        @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_tick(ok, gap);
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL zero_tick%0d: no baud_tick within bound, expected one", k);
            end else if (tx_serial !== exp[k]) begin
                errors++;
                $display("FAIL zero_bit%0d: serial=%b expected %b", k, tx_serial, exp[k]);
            end
            if (ok && k > 0) begin
                vectors++;
                if (gap != longint'(DIV)) begin
                    errors++;
                    $display("FAIL zero_len%0d: bit lasted %0d clks expected %0d", k, gap, DIV);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_end: busy=%b expected 0", tx_busy);
        end
    endtask

    task automatic test_back_to_back;
        bit ok; longint gap; logic [9:0] exp;
        logic [7:0] q[$];
        int n;
        n = int'($urandom_range(12, 10));
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        @(negedge clk);
        tx_data  = q[0];
        tx_start = 1'b1;
        for (int f = 0; f < n; f++) begin
            exp = frame_of(q[f]);
            for (int k = 0; k < 10; k++) begin
                wait_tick(ok, gap);
                vectors++;
                if (!ok) begin
                    errors++;
                    $display("FAIL b2b_f%0d_tick%0d: no baud_tick within bound, expected one", f, k);
                end else if (tx_serial !== exp[k]) begin
                    errors++;
                    $display("FAIL b2b_f%0d_bit%0d: serial=%b expected %b (byte %h)", f, k, tx_serial, exp[k], q[f]);
                end
                // One idle clock separates frames when tx_start stays high.
                if (ok && f > 0 && k == 0) begin
                    vectors++;
                    if (gap != longint'(DIV + 1)) begin
                        errors++;
                        $display("FAIL b2b_f%0d_gap: %0d clks expected %0d", f, gap, DIV + 1);
                    end
                end
                if (k == 3) tx_data = 8'($urandom);
                if (k == 9) begin
                    if (f < n - 1) tx_data = q[f + 1];
                    else           tx_start = 1'b0;
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: serial=%b busy=%b expected serial=1 busy=0", tx_serial, tx_busy);
        end
    endtask

    task automatic test_busy_ignore;
        bit ok; longint gap; logic [9:0] exp; bit stray;
        exp = frame_of(8'h31);
        @(negedge clk);
        tx_data  = 8'h31;
        tx_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_tick(ok, gap);
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL ign_tick%0d: no baud_tick within bound, expected one", k);
            end else if (tx_serial !== exp[k]) begin
                errors++;
                $display("FAIL ign_bit%0d: serial=%b expected %b", k, tx_serial, exp[k]);
            end
            if (k == 5) begin
                tx_start = 1'b1;
                tx_data  = 8'($urandom);
                @(negedge clk);
                @(negedge clk);
                tx_start = 1'b0;
            end
        end
        stray = 1'b0;
        for (int i = 0; i < int'(DIV) + 20; i++) begin
            @(negedge clk);
            if (i > 0 && (tx_busy !== 1'b0 || tx_serial !== 1'b1)) stray = 1'b1;
        end
        vectors++;
        if (stray) begin
            errors++;
            $display("FAIL ign_no_second_frame: line left idle=%b expected idle=1", !stray);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok; longint gap; logic [9:0] exp; logic [7:0] b;
        b = 8'($urandom);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 0; k < 4; k++) wait_tick(ok, gap);
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        vectors++;
        if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: serial=%b busy=%b expected serial=1 busy=0", tx_serial, tx_busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: serial=%b busy=%b expected serial=1 busy=0", tx_serial, tx_busy);
        end
        b   = 8'($urandom);
        exp = frame_of(b);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        last_tick = cyc;
        for (int k = 0; k < 10; k++) begin
            wait_tick(ok, gap);
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL clean_tick%0d: no baud_tick within bound, expected one", k);
            end else if (tx_serial !== exp[k]) begin
                errors++;
                $display("FAIL clean_bit%0d: serial=%b expected %b (byte %h)", k, tx_serial, exp[k], b);
            end
            if (ok) begin
                vectors++;
                if (gap != longint'((k == 0) ? DIV - 1 : DIV)) begin
                    errors++;
                    $display("FAIL clean_len%0d: %0d clks expected %0d", k, gap, (k == 0) ? DIV - 1 : DIV);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL clean_end: serial=%b busy=%b expected serial=1 busy=0", tx_serial, tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
